wb_rr_arbiter: RTL and testbench

Round-robin Wishbone classic arbiter that shares a single `wb_slave_if`-side target among `NUM_M` Wishbone masters. It sits between the master interfaces and the DUT slave port in the testbench top or SoC fabric, granting whole bus cycles (`cyc`-framed) to one master at a time. A per-transfer watchdog terminates stalled slave accesses with an error.

---
 rtl/wb_rr_arbiter_if.sv | 53 +++++
 rtl/wb_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between NUM_M Wishbone masters, the round-robin arbiter and the
// shared slave. The "slave" modport is the arbiter's view of the bundle: it
// answers the masters and drives the shared slave port. The "master" modport
// is the surrounding fabric or bench, which drives the masters' requests and
// the slave's responses.
interface wb_rr_arbiter_if #(
  parameter int NUM_M = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  // master-side request signals, packed per master
  logic [NUM_M-1:0]        m_cyc_i;
  logic [NUM_M-1:0]        m_stb_i;
  logic [NUM_M-1:0]        m_we_i;
  logic [NUM_M*AW-1:0]     m_adr_i;
  logic [NUM_M*DW-1:0]     m_dat_i;
  logic [NUM_M*DW/8-1:0]   m_sel_i;
  // master-side responses
  logic [DW-1:0]           m_dat_o;
  logic [NUM_M-1:0]        m_ack_o;
  logic [NUM_M-1:0]        m_err_o;
  logic [NUM_M-1:0]        m_rty_o;
  // shared slave port
  logic                    s_cyc_o;
  logic                    s_stb_o;
  logic                    s_we_o;
  logic [AW-1:0]           s_adr_o;
  logic [DW-1:0]           s_dat_o;
  logic [DW/8-1:0]         s_sel_o;
  logic [DW-1:0]           s_dat_i;
  logic                    s_ack_i;
  logic                    s_err_i;
  logic                    s_rty_i;
  // status
  logic [NUM_M-1:0]        gnt_o;
  logic                    timeout_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output gnt_o, timeout_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  gnt_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter. A whole cyc-framed bus cycle is
// granted to one master at a time; the owner's request is muxed straight to
// the shared slave and the slave's terminations go back to the owner only.
// A per-transfer watchdog aborts a strobe the slave leaves unterminated for
// TIMEOUT cycles by inserting a one-cycle error (ABORT) to the owner.
module wb_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_rr_arbiter_if.slave  bus
);

  localparam int          LW       = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int          SW       = DW / 8;
  localparam bit          WD_EN    = (TIMEOUT != 0);
  localparam logic [15:0] WD_LIMIT = WD_EN ? 16'(TIMEOUT - 1) : 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_M-1:0]  gnt_q,   gnt_d;
  logic [LW-1:0]     last_q,  last_d;   // previous / current owner index
  logic [15:0]       wd_q,    wd_d;

  logic              win_vld_s;
  logic [LW-1:0]     win_idx_s;
  logic [LW-1:0]     cand_s;

  logic              own_cyc_s;
  logic              own_stb_s;
  logic              own_we_s;
  logic [AW-1:0]     own_adr_s;
  logic [DW-1:0]     own_dat_s;
  logic [SW-1:0]     own_sel_s;
  logic              term_s;

  // Rotating priority search: scanning offsets from far to near lets the
  // nearest requester after last_q overwrite earlier candidates.
  always_comb begin
    win_vld_s = |bus.m_cyc_i;
    win_idx_s = last_q;
    cand_s    = last_q;
    for (int k = NUM_M; k >= 1; k--) begin
      cand_s    = LW'((int'(last_q) + k) % NUM_M);
      win_idx_s = bus.m_cyc_i[cand_s] ? cand_s : win_idx_s;
    end
  end

  // Select the current owner's request fields; last_q holds the owner while
  // a grant is active.
  always_comb begin
    own_cyc_s = bus.m_cyc_i[last_q];
    own_stb_s = bus.m_stb_i[last_q];
    own_we_s  = bus.m_we_i[last_q];
    own_adr_s = bus.m_adr_i[int'(last_q) * AW +: AW];
    own_dat_s = bus.m_dat_i[int'(last_q) * DW +: DW];
    own_sel_s = bus.m_sel_i[int'(last_q) * SW +: SW];
    term_s    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  end

  // Next-state logic: arbitration, ownership release and watchdog.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wd_d    = 16'd0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_d = ST_OWN;
          gnt_d   = {{(NUM_M-1){1'b0}}, 1'b1} << win_idx_s;
          last_d  = win_idx_s;
        end else begin
          gnt_d   = {NUM_M{1'b0}};
        end
      end
      ST_OWN: begin
        if (!own_cyc_s) begin
          // owner closed its cycle: release and leave one dead cycle
          state_d = ST_IDLE;
          gnt_d   = {NUM_M{1'b0}};
        end else if (own_stb_s && !term_s) begin
          if (WD_EN && (wd_q == WD_LIMIT)) begin
            state_d = ST_ABORT;
          end else begin
            wd_d    = wd_q + 16'd1;
          end
        end else begin
          // a termination (even at the limit) or an idle strobe restarts
          wd_d    = 16'd0;
        end
      end
      ST_ABORT: begin
        if (own_cyc_s) begin
          state_d = ST_OWN;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = {NUM_M{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {NUM_M{1'b0}};
      end
    endcase
  end

  // State, grant, owner history and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= {NUM_M{1'b0}};
      last_q  <= LW'(NUM_M - 1);
      wd_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Bus outputs: combinational pass-through of the owner in OWN, forced
  // error in ABORT, everything quiet otherwise. Because these decode the
  // asynchronously reset state, a reset silences the slave port at once.
  always_comb begin
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_adr_o   = {AW{1'b0}};
    bus.s_dat_o   = {DW{1'b0}};
    bus.s_sel_o   = {SW{1'b0}};
    bus.m_ack_o   = {NUM_M{1'b0}};
    bus.m_err_o   = {NUM_M{1'b0}};
    bus.m_rty_o   = {NUM_M{1'b0}};
    bus.timeout_o = 1'b0;
    bus.m_dat_o   = bus.s_dat_i;
    case (state_q)
      ST_OWN: begin
        bus.s_cyc_o          = own_cyc_s;
        bus.s_stb_o          = own_stb_s;
        bus.s_we_o           = own_we_s;
        bus.s_adr_o          = own_adr_s;
        bus.s_dat_o          = own_dat_s;
        bus.s_sel_o          = own_sel_s;
        bus.m_ack_o[last_q]  = bus.s_ack_i;
        bus.m_err_o[last_q]  = bus.s_err_i;
        bus.m_rty_o[last_q]  = bus.s_rty_i;
      end
      ST_ABORT: begin
        bus.m_err_o[last_q]  = 1'b1;
        bus.timeout_o        = 1'b1;
      end
      default: begin
        bus.timeout_o = 1'b0;
      end
    endcase
  end

  // Grant vector is the registered owner.
  always_comb begin
    bus.gnt_o = gnt_q;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios with constant
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_wb_rr_arbiter;
  localparam int NUM_M   = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_rr_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic clear_inputs();
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
    bus.m_we_i  = 4'b0000;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_dat_i = 32'h0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
  endtask

  // returns at a falling edge with reset just released
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.s_dat_i = 32'hA5A5_5A5A;
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b1;
    bus.s_rty_i = 1'b1;
    #3;
    n_checks++;
    if (bus.gnt_o !== 4'b0000 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 ||
        bus.s_adr_o !== 32'h0 || bus.timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: gnt=%b cyc=%b stb=%b adr=%h to=%b, want 0", bus.gnt_o,
               bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.timeout_o);
    end
    n_checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.m_rty_o !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_terms: ack=%b err=%b rty=%b, want 0000", bus.m_ack_o, bus.m_err_o, bus.m_rty_o);
    end
    n_checks++;
    if (bus.m_dat_o !== 32'hA5A5_5A5A) begin
      n_errors++;
      $display("FAIL reset_rdata: got %h want a5a55a5a", bus.m_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.m_rty_o !== 4'b0 || bus.gnt_o !== 4'b0) begin
      n_errors++;
      $display("FAIL idle_terms_ignored: ack=%b err=%b rty=%b gnt=%b, want 0", bus.m_ack_o,
               bus.m_err_o, bus.m_rty_o, bus.gnt_o);
    end
    clear_inputs();
  endtask

  task automatic test_single_master();
    do_reset();
    bus.m_cyc_i[2] = 1'b1;
    bus.m_stb_i[2] = 1'b1;
    bus.m_we_i[2]  = 1'b1;
    bus.m_adr_i[2*AW +: AW] = 32'h10;
    bus.m_dat_i[2*DW +: DW] = 32'hCAFE_0002;
    bus.m_sel_i[2*4 +: 4]   = 4'hF;
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_pre_grant: gnt=%b want 0000", bus.gnt_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b0100 || bus.s_cyc_o !== 1'b1 || bus.s_we_o !== 1'b1 ||
        bus.s_adr_o !== 32'h10 || bus.s_dat_o !== 32'hCAFE_0002 || bus.s_sel_o !== 4'hF) begin
      n_errors++;
      $display("FAIL single_grant: gnt=%b cyc=%b we=%b adr=%h dat=%h sel=%h, want 0100 1 1 10 cafe0002 f",
               bus.gnt_o, bus.s_cyc_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
    end
    bus.s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (bus.m_ack_o !== 4'b0100) begin
      n_errors++;
      $display("FAIL single_ack: m_ack=%b want 0100", bus.m_ack_o);
    end
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
    #1;
    n_checks++;
    if (bus.m_ack_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_ack_one_cycle: m_ack=%b want 0000", bus.m_ack_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_release: gnt=%b want 0000", bus.gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    bus.m_cyc_i = 4'b1111;
    bus.m_stb_i = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp = 4'b0001 << (r % 4);
      @(negedge clk);
      bus.s_ack_i = 1'b1;
      #1;
      n_checks++;
      if (bus.gnt_o !== exp || bus.m_ack_o !== exp) begin
        n_errors++;
        $display("FAIL rr_grant_%0d: gnt=%b ack=%b want %b", r, bus.gnt_o, bus.m_ack_o, exp);
      end
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i = bus.m_cyc_i & ~exp;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.gnt_o !== 4'b0000) begin
        n_errors++;
        $display("FAIL rr_dead_cycle_%0d: gnt=%b want 0000", r, bus.gnt_o);
      end
      bus.m_cyc_i = 4'b1111;
    end
    clear_inputs();
  endtask

  task automatic test_burst_hold();
    do_reset();
    bus.m_cyc_i[1] = 1'b1;
    bus.m_stb_i[1] = 1'b1;
    @(negedge clk);
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.m_adr_i[1*AW +: AW] = 32'h100 + 32'(b * 4);
      bus.s_ack_i = 1'b1;
      #1;
      n_checks++;
      if (bus.gnt_o !== 4'b0010 || bus.m_ack_o !== 4'b0010 || bus.s_adr_o !== 32'h100 + 32'(b * 4)) begin
        n_errors++;
        $display("FAIL burst_beat_%0d: gnt=%b ack=%b adr=%h want 0010 0010 %h", b, bus.gnt_o,
                 bus.m_ack_o, bus.s_adr_o, 32'h100 + 32'(b * 4));
      end
      @(negedge clk);
    end
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i[1] = 1'b0;
    bus.m_stb_i[1] = 1'b0;
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b0010) begin
      n_errors++;
      $display("FAIL burst_still_held: gnt=%b want 0010", bus.gnt_o);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL burst_next_owner: gnt=%b want 0001", bus.gnt_o);
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.gnt_o !== 4'b0001 || bus.s_stb_o !== 1'b1 || bus.m_err_o !== 4'b0 || bus.timeout_o !== 1'b0) begin
        n_errors++;
        $display("FAIL wd_wait_%0d: gnt=%b stb=%b err=%b to=%b want 0001 1 0000 0", i, bus.gnt_o,
                 bus.s_stb_o, bus.m_err_o, bus.timeout_o);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.timeout_o !== 1'b1 || bus.m_err_o !== 4'b0001 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
      n_errors++;
      $display("FAIL wd_abort: to=%b err=%b cyc=%b stb=%b want 1 0001 0 0", bus.timeout_o,
               bus.m_err_o, bus.s_cyc_o, bus.s_stb_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.timeout_o !== 1'b0 || bus.m_err_o !== 4'b0 || bus.s_cyc_o !== 1'b1) begin
      n_errors++;
      $display("FAIL wd_after_abort: to=%b err=%b cyc=%b want 0 0000 1", bus.timeout_o, bus.m_err_o, bus.s_cyc_o);
    end
    clear_inputs();
  endtask

  task automatic test_race_at_limit();
    do_reset();
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    bus.s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (bus.m_ack_o !== 4'b0001 || bus.timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL race_ack: ack=%b to=%b want 0001 0", bus.m_ack_o, bus.timeout_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      #1;
      n_checks++;
      if (bus.timeout_o !== 1'b0 || bus.m_err_o !== 4'b0 || bus.s_cyc_o !== 1'b1) begin
        n_errors++;
        $display("FAIL race_no_abort_%0d: to=%b err=%b cyc=%b want 0 0000 1", i, bus.timeout_o,
                 bus.m_err_o, bus.s_cyc_o);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.m_cyc_i[3] = 1'b1;
    bus.m_stb_i[3] = 1'b1;
    @(negedge clk);
    bus.s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b1000 || bus.s_cyc_o !== 1'b1 || bus.m_ack_o !== 4'b1000) begin
      n_errors++;
      $display("FAIL midrst_owned: gnt=%b cyc=%b ack=%b want 1000 1 1000", bus.gnt_o, bus.s_cyc_o, bus.m_ack_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.gnt_o !== 4'b0000 || bus.m_ack_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL midrst_async: cyc=%b stb=%b gnt=%b ack=%b want 0 0 0000 0000", bus.s_cyc_o,
               bus.s_stb_o, bus.gnt_o, bus.m_ack_o);
    end
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.gnt_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL midrst_priority: gnt=%b want 0001", bus.gnt_o);
    end
    clear_inputs();
  endtask

  // Randomized traffic against a behavioural model: mode 0 idle, 1 owned,
  // 2 abort cycle; wd counts consecutive unterminated strobe cycles.
  task automatic test_random();
    int mode, owner, last, wd, w, c;
    logic [3:0]  e_gnt, e_ack, e_err, e_rty;
    logic        e_cyc, e_stb, e_we, e_to;
    logic [31:0] e_adr;
    logic        t_any;
    do_reset();
    mode = 0; owner = 0; last = NUM_M - 1; wd = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_M; i++) begin
        if ($urandom_range(0, 7) == 0) bus.m_cyc_i[i] = ~bus.m_cyc_i[i];
        bus.m_stb_i[i] = bus.m_cyc_i[i] & ($urandom_range(0, 7) != 0);
        bus.m_we_i[i]  = 1'($urandom_range(0, 1));
        bus.m_adr_i[i*AW +: AW] = $urandom;
        bus.m_dat_i[i*DW +: DW] = $urandom;
        bus.m_sel_i[i*4 +: 4]   = 4'($urandom_range(0, 15));
      end
      bus.s_dat_i = $urandom;
      bus.s_ack_i = ($urandom_range(0, 13) == 0);
      bus.s_err_i = ($urandom_range(0, 39) == 0);
      bus.s_rty_i = ($urandom_range(0, 39) == 0);
      #1;
      e_gnt = (mode == 0) ? 4'b0000 : (4'b0001 << owner);
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = 32'h0; e_to = 1'b0;
      e_ack = 4'b0; e_err = 4'b0; e_rty = 4'b0;
      if (mode == 1) begin
        e_cyc = bus.m_cyc_i[owner];
        e_stb = bus.m_stb_i[owner];
        e_we  = bus.m_we_i[owner];
        e_adr = bus.m_adr_i[owner*AW +: AW];
        e_ack = bus.s_ack_i ? (4'b0001 << owner) : 4'b0;
        e_err = bus.s_err_i ? (4'b0001 << owner) : 4'b0;
        e_rty = bus.s_rty_i ? (4'b0001 << owner) : 4'b0;
      end else if (mode == 2) begin
        e_err = 4'b0001 << owner;
        e_to  = 1'b1;
      end
      n_checks++;
      if (bus.gnt_o !== e_gnt) begin
        n_errors++;
        $display("FAIL rand_gnt cyc%0d: got %b want %b", n, bus.gnt_o, e_gnt);
      end
      n_checks++;
      if (bus.s_cyc_o !== e_cyc || bus.s_stb_o !== e_stb || bus.s_we_o !== e_we || bus.s_adr_o !== e_adr) begin
        n_errors++;
        $display("FAIL rand_slave cyc%0d: got %b%b%b %h want %b%b%b %h", n, bus.s_cyc_o, bus.s_stb_o,
                 bus.s_we_o, bus.s_adr_o, e_cyc, e_stb, e_we, e_adr);
      end
      n_checks++;
      if (bus.m_ack_o !== e_ack || bus.m_err_o !== e_err || bus.m_rty_o !== e_rty || bus.timeout_o !== e_to) begin
        n_errors++;
        $display("FAIL rand_terms cyc%0d: got %b %b %b %b want %b %b %b %b", n, bus.m_ack_o, bus.m_err_o,
                 bus.m_rty_o, bus.timeout_o, e_ack, e_err, e_rty, e_to);
      end
      n_checks++;
      if (bus.m_dat_o !== bus.s_dat_i) begin
        n_errors++;
        $display("FAIL rand_rdata cyc%0d: got %h want %h", n, bus.m_dat_o, bus.s_dat_i);
      end
      @(posedge clk);
      t_any = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
      if (mode == 0) begin
        w = -1;
        for (int k = 1; k <= NUM_M; k++) begin
          c = (last + k) % NUM_M;
          if (w < 0 && bus.m_cyc_i[c[1:0]]) w = c;
        end
        if (w >= 0) begin
          mode = 1; owner = w; last = w;
        end
        wd = 0;
      end else if (mode == 1) begin
        if (!bus.m_cyc_i[owner]) begin
          mode = 0; wd = 0;
        end else if (bus.m_stb_i[owner] && !t_any) begin
          if (wd == TIMEOUT - 1) begin
            mode = 2; wd = 0;
          end else begin
            wd = wd + 1;
          end
        end else begin
          wd = 0;
        end
      end else begin
        mode = bus.m_cyc_i[owner] ? 1 : 0;
        wd = 0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_master();
    test_round_robin();
    test_burst_hold();
    test_watchdog();
    test_race_at_limit();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
